// File: rtl/tohost_monitor_if.sv
// Memory write-port snoop bundle: one accepted write beat per cycle when wr_valid is high.
interface tohost_monitor_if #(
  parameter int ADDR_W = 32
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;
  logic [7:0]        wr_mask;

  modport master (output wr_valid, wr_addr, wr_data, wr_mask);
  modport slave  (input  wr_valid, wr_addr, wr_data, wr_mask);
endinterface

// File: rtl/tohost_monitor.sv
// HTIF tohost snooper: decodes exit/putchar stores and queues console characters.
// Optional VARIANT_COMPARE_EN adds a second harness port and a divergence detector.
module tohost_monitor_side #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h8000_1000
) (
  input  logic                   clock,
  input  logic                   reset,
  tohost_monitor_if.slave        wr,
  output logic                   push_valid,
  output logic [7:0]             push_char,
  output logic                   bad_pulse,
  output logic                   done,
  output logic [62:0]            exit_code
);
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(7));

  state_t      state, state_next;
  logic [63:0] shadow, shadow_next;
  logic [62:0] code_next;
  logic        hit, trigger;
  logic [7:0]  dev, cmd;
  logic        do_exit;

  assign hit     = wr.wr_valid && ((wr.wr_addr & ADDR_MASK) == (TOHOST_ADDR & ADDR_MASK));
  assign trigger = hit && wr.wr_mask[7];
  assign dev     = shadow[63:56];
  assign cmd     = shadow[55:48];

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_next = state;
    shadow_next = shadow;
    code_next  = exit_code;
    do_exit    = 1'b0;
    push_valid = 1'b0;
    push_char  = shadow[7:0];
    bad_pulse  = 1'b0;

    if (state == EVAL) begin
      // The host zeroes tohost after reading it; a same-cycle hit lands on the cleared word.
      shadow_next = '0;
      if (shadow != '0) begin
        if (dev == 8'd0 && shadow[0])         do_exit    = 1'b1;
        else if (dev == 8'd1 && cmd == 8'd1)  push_valid = 1'b1;
        else                                  bad_pulse  = 1'b1;
      end
    end

    if (hit && state != DONE) begin
      for (int b = 0; b < 8; b++) begin
        if (wr.wr_mask[b]) shadow_next[8*b +: 8] = wr.wr_data[8*b +: 8];
      end
    end

    case (state)
      IDLE: if (trigger) state_next = EVAL;
      EVAL: begin
        if (do_exit) begin
          state_next = DONE;
          code_next  = shadow[63:1];
        end else if (trigger) begin
          state_next = EVAL;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = state;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shadow    <= '0;
      exit_code <= '0;
    end else begin
      state     <= state_next;
      shadow    <= shadow_next;
      exit_code <= code_next;
    end
  end

  assign done = (state == DONE);
endmodule

module tohost_monitor #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h8000_1000,
  parameter int                FIFO_DEPTH  = 8
) (
  input  logic            clock,
  input  logic            reset,
  tohost_monitor_if.slave wr,
`ifdef VARIANT_COMPARE_EN
  tohost_monitor_if.slave vnt_wr,
  output logic            diverge,
`endif
  output logic [63:0]     tohost,
  output logic            done,
  output logic            pass,
  output logic [62:0]     exit_code,
  output logic            bad_cmd,
  output logic            putc_valid,
  output logic [7:0]      putc_data,
  input  logic            putc_ready,
  output logic            putc_ovf
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic        push_valid, bad_pulse, main_done;
  logic [7:0]  push_char;
  logic [62:0] main_code;

  tohost_monitor_side #(.ADDR_W(ADDR_W), .TOHOST_ADDR(TOHOST_ADDR)) u_main (
    .clock      (clock),
    .reset      (reset),
    .wr         (wr),
    .push_valid (push_valid),
    .push_char  (push_char),
    .bad_pulse  (bad_pulse),
    .done       (main_done),
    .exit_code  (main_code)
  );

`ifdef VARIANT_COMPARE_EN
  logic        vnt_push_valid, vnt_bad_pulse, vnt_done;
  logic [7:0]  vnt_push_char;
  logic [62:0] vnt_code;
  logic [9:0]  lag_cnt;

  // Only the primary harness feeds the console; the variant side is tracked for its exit event.
  tohost_monitor_side #(.ADDR_W(ADDR_W), .TOHOST_ADDR(TOHOST_ADDR)) u_vnt (
    .clock      (clock),
    .reset      (reset),
    .wr         (vnt_wr),
    .push_valid (vnt_push_valid),
    .push_char  (vnt_push_char),
    .bad_pulse  (vnt_bad_pulse),
    .done       (vnt_done),
    .exit_code  (vnt_code)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      lag_cnt <= '0;
      diverge <= 1'b0;
    end else begin
      if (main_done != vnt_done) begin
        if (lag_cnt == 10'd1023) diverge <= 1'b1;
        else                     lag_cnt <= lag_cnt + 10'd1;
      end else begin
        lag_cnt <= '0;
      end
      if (main_done && vnt_done && main_code != vnt_code) diverge <= 1'b1;
    end
  end

  assign done      = main_done && vnt_done;
  assign exit_code = done ? main_code : '0;
  assign pass      = done && main_code == '0 && vnt_code == '0 && !diverge;
  wire   bad_any   = bad_pulse || vnt_bad_pulse;
`else
  assign done      = main_done;
  assign exit_code = main_code;
  assign pass      = done && exit_code == '0;
  wire   bad_any   = bad_pulse;
`endif

  assign tohost = done ? {exit_code, 1'b1} : 64'd0;

  always_ff @(posedge clock) begin
    if (reset) bad_cmd <= 1'b0;
    else if (bad_any) bad_cmd <= 1'b1;
  end

  // Console FIFO; a push into a full FIFO is accepted only when a pop frees the head slot.
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic             full, pop, push;

  assign full       = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign putc_valid = (count != '0);
  assign putc_data  = fifo_mem[rd_ptr];
  assign pop        = putc_valid && putc_ready;
  assign push       = push_valid && (!full || pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      putc_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
      if (push_valid && !push) putc_ovf <= 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= push_char;
  end
endmodule

// File: tb/tb_tohost_monitor.sv
// Self-checking bench for tohost_monitor: directed scenarios plus randomized putchar/exit traffic.
module tb_tohost_monitor;
  localparam logic [31:0] TOHOST = 32'h8000_1000;
  localparam int          DEPTH  = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] tohost;
  logic        done, pass, bad_cmd, putc_valid, putc_ready, putc_ovf;
  logic [62:0] exit_code;
  logic [7:0]  putc_data;

  tohost_monitor_if #(.ADDR_W(32)) wr_bus ();

  tohost_monitor #(.ADDR_W(32), .TOHOST_ADDR(TOHOST), .FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr         (wr_bus),
    .tohost     (tohost),
    .done       (done),
    .pass       (pass),
    .exit_code  (exit_code),
    .bad_cmd    (bad_cmd),
    .putc_valid (putc_valid),
    .putc_data  (putc_data),
    .putc_ready (putc_ready),
    .putc_ovf   (putc_ovf)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Transaction-level reference state.
  logic [63:0] m_shadow;
  logic        m_done, m_bad, m_ovf;
  logic [62:0] m_code;
  int          m_occ;
  logic [7:0]  exp_chars[$];
  logic [7:0]  got_chars[$];

  always @(posedge clock) begin
    if (!reset && putc_valid && putc_ready) got_chars.push_back(putc_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_shadow = '0; m_done = 1'b0; m_bad = 1'b0; m_ovf = 1'b0; m_code = '0; m_occ = 0;
    exp_chars.delete();
    got_chars.delete();
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] mask);
    logic [63:0] snap;
    if ((addr >> 3) != (TOHOST >> 3) || m_done) return;
    for (int b = 0; b < 8; b++) if (mask[b]) m_shadow[8*b +: 8] = data[8*b +: 8];
    if (!mask[7]) return;
    snap = m_shadow;
    m_shadow = '0;
    if (snap == 64'd0) return;
    if (snap[63:56] == 8'd0 && snap[0]) begin
      m_done = 1'b1;
      m_code = snap[63:1];
    end else if (snap[63:56] == 8'd1 && snap[55:48] == 8'd1) begin
      if (putc_ready || m_occ < DEPTH) begin
        exp_chars.push_back(snap[7:0]);
        if (!putc_ready) m_occ++;
      end else begin
        m_ovf = 1'b1;
      end
    end else begin
      m_bad = 1'b1;
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] mask);
    @(negedge clock);
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_addr  = addr;
    wr_bus.wr_data  = data;
    wr_bus.wr_mask  = mask;
    model_write(addr, data, mask);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      wr_bus.wr_valid = 1'b0;
    end
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b1;
    wr_bus.wr_valid = 1'b0;
    putc_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_status(input string tag);
    check({tag, ".done"}, done, m_done);
    check({tag, ".pass"}, pass, m_done && m_code == '0);
    check({tag, ".exit_code"}, exit_code, m_done ? m_code : 63'd0);
    check({tag, ".tohost"}, tohost, m_done ? {m_code, 1'b1} : 64'd0);
    check({tag, ".bad_cmd"}, bad_cmd, m_bad);
    check({tag, ".putc_ovf"}, putc_ovf, m_ovf);
  endtask

  task automatic drain(input string tag);
    putc_ready = 1'b1;
    idle(DEPTH + 4);
    putc_ready = 1'b0;
    m_occ = 0;
    check({tag, ".count"}, got_chars.size(), exp_chars.size());
    for (int i = 0; i < exp_chars.size() && i < got_chars.size(); i++)
      check($sformatf("%s.char%0d", tag, i), got_chars[i], exp_chars[i]);
    check({tag, ".empty"}, putc_valid, 1'b0);
    exp_chars.delete();
    got_chars.delete();
  endtask

  function automatic logic [63:0] putc_word(input logic [7:0] c);
    return {8'h01, 8'h01, 40'd0, c};
  endfunction

  initial begin
    logic [7:0] first_char;
    logic [63:0] data;
    int n;
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_addr  = '0;
    wr_bus.wr_data  = '0;
    wr_bus.wr_mask  = '0;
    putc_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);

    // Reset state.
    reset_dut();
    check_status("reset");
    check("reset.putc_valid", putc_valid, 1'b0);

    // sd 1: done two cycles after the store, not one.
    store(TOHOST, 64'h1, 8'hFF);
    idle(1);
    check("t1.eval_done", done, 1'b0);
    idle(1);
    check_status("t1");

    // Non-zero exit code; later stores are absorbed.
    reset_dut();
    store(TOHOST, 64'h7, 8'hFF);
    idle(2);
    check_status("t2");
    check("t2.code3", exit_code, 63'd3);
    store(TOHOST, 64'h1, 8'hFF);
    idle(3);
    check_status("t2.after");

    // Back-to-back putchars with the consumer ready.
    reset_dut();
    putc_ready = 1'b1;
    store(TOHOST, 64'h0101_0000_0000_0041, 8'hFF);
    store(TOHOST, 64'h0101_0000_0000_0042, 8'hFF);
    idle(4);
    check("t3.first", got_chars.size() > 0 ? got_chars[0] : 8'hxx, 8'h41);
    check_status("t3");
    drain("t3.drain");

    // Overflow: DEPTH+1 chars with the consumer stalled; head must hold.
    reset_dut();
    for (int i = 0; i <= DEPTH; i++) store(TOHOST | 32'(i % 8), putc_word(8'h61 + 8'(i)), 8'hFF);
    idle(3);
    check("t4.valid", putc_valid, 1'b1);
    check_status("t4");
    first_char = exp_chars[0];
    check("t4.head", putc_data, first_char);
    idle(3);
    check("t4.head_hold", putc_data, first_char);
    drain("t4.drain");

    // RV32 split store: nothing until the high word lands.
    reset_dut();
    store(TOHOST, 64'h1, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check($sformatf("t5.wait%0d", i), done, 1'b0);
    end
    store(TOHOST + 32'd4, 64'h0, 8'hF0);
    idle(1);
    check("t5.eval_done", done, 1'b0);
    idle(1);
    check_status("t5");
    reset_dut();
    store(TOHOST, 64'h0200_0000_0000_0000, 8'hFF);
    idle(3);
    check_status("t5.bad");

    // Reset during EVAL with chars queued.
    reset_dut();
    for (int i = 0; i < 3; i++) store(TOHOST, putc_word(8'h30 + 8'(i)), 8'hFF);
    idle(2);
    check("t6.queued", putc_valid, 1'b1);
    store(TOHOST, putc_word(8'h39), 8'hFF);
    idle(1);
    reset = 1'b1;
    @(negedge clock);
    model_reset();
    check_status("t6.reset");
    check("t6.empty", putc_valid, 1'b0);
    reset = 1'b0;
    store(TOHOST, 64'h1, 8'hFF);
    idle(2);
    check_status("t6.pass");

    // Randomized putchar/noise/bad traffic followed by a random exit.
    for (int iter = 0; iter < 6; iter++) begin
      reset_dut();
      n = $urandom_range(1, DEPTH + 3);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 5))
          0: store(TOHOST ^ (32'h8 << $urandom_range(0, 28)), {$urandom, $urandom}, 8'hFF);
          1: store(TOHOST | 32'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom_range(0, 127)));
          2: store(TOHOST, {8'($urandom_range(2, 255)), 24'($urandom), 32'($urandom)}, 8'hFF);
          default: ;
        endcase
        store(TOHOST | 32'($urandom_range(0, 7)), putc_word(8'($urandom)), 8'hFF);
        idle($urandom_range(0, 1));
      end
      idle(3);
      check_status($sformatf("r%0d.chars", iter));
      drain($sformatf("r%0d.drain", iter));
      data = ($urandom_range(0, 3) == 0) ? 64'h1 : {8'h00, 24'($urandom), 31'($urandom), 1'b1};
      store(TOHOST, data, 8'hFF);
      idle(2);
      check_status($sformatf("r%0d.exit", iter));
      store(TOHOST, {$urandom, $urandom}, 8'hFF);
      idle(3);
      check_status($sformatf("r%0d.absorb", iter));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
